// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared types and helpers for the CNN layer sequencer.
//   seq_state_t : sequencer FSM states
//   DATA_W_DEF  : default width of the final-stage result
//   relu_clamp  : 1 when a captured result must be forced to zero
package cnn_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERROR
  } seq_state_t;

  localparam int DATA_W_DEF = 32;

  // Negative results are clamped only when ReLU is enabled.
  function automatic logic relu_clamp(input logic sign_bit, input logic relu_en);
    return sign_bit & relu_en;
  endfunction

endpackage

// File: rtl/cnn_layer_sequencer_watchdog.sv
// Per-stage watchdog for the layer sequencer.
//   clk_i/rst_i : clock, synchronous active-low reset
//   clr_i       : restart the count (stage start)
//   en_i        : count one waiting cycle
//   expired_o   : this waiting cycle is the TIMEOUT-th one; TIMEOUT=0 never expires
module cnn_layer_sequencer_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired_o = 1'b0;
    end else begin : g_on
      // Flag on the cycle whose increment would reach TIMEOUT.
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
      assign expired_o = en_i && (cnt_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences N_STAGES layer engines through start/done handshakes.
//   clk_i, rst_i          : clock, synchronous active-low reset
//   enable_i              : start request; keeps continuous mode running
//   continuous_i          : rerun next frame (sampled in DONE)
//   abort_i               : return to IDLE next cycle, clears error
//   stage_start_o         : one-hot single-cycle start pulse
//   stage_done_i          : per-stage done (rising edge is used)
//   last_result_i         : signed result of the final stage
//   result_o              : captured, optionally ReLU'd, result
//   done_o                : one-cycle pulse per completed frame
//   busy_o/error_o        : in START/WAIT, in ERROR
//   err_stage_o           : stage that timed out
//   cur_stage_o           : stage in progress
//   frame_count_o         : completed frames, wrapping
module cnn_layer_sequencer
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int N_STAGES = 3,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TIMEOUT  = 1024,
  parameter int FRAME_W  = 16,
  parameter int RELU_EN  = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      continuous_i,
  input  logic                      abort_i,
  output logic [N_STAGES-1:0]       stage_start_o,
  input  logic [N_STAGES-1:0]       stage_done_i,
  input  logic [DATA_W-1:0]         last_result_i,
  output logic [DATA_W-1:0]         result_o,
  output logic                      done_o,
  output logic                      busy_o,
  output logic                      error_o,
  output logic [$clog2(N_STAGES):0] err_stage_o,
  output logic [$clog2(N_STAGES):0] cur_stage_o,
  output logic [FRAME_W-1:0]        frame_count_o
);

  localparam int IW = $clog2(N_STAGES) + 1;
  localparam logic [IW-1:0] LAST = IW'(N_STAGES - 1);

  seq_state_t          state_q;
  logic [IW-1:0]       idx_q, err_stage_q;
  logic [N_STAGES-1:0] done_hist_q, start_q;
  logic [DATA_W-1:0]   result_q;
  logic [FRAME_W-1:0]  frame_q;
  logic                seen_q, done_q, busy_q, error_q;

  logic [N_STAGES-1:0] done_rise, idx_oh;
  logic                hit, wd_expired;

  assign done_rise = stage_done_i & ~done_hist_q;
  assign idx_oh    = N_STAGES'(1) << idx_q;
  // A rise during START is remembered in seen_q so zero-latency stages still advance.
  assign hit       = seen_q | (|(done_rise & idx_oh));

  cnn_layer_sequencer_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == S_START),
    .en_i      (state_q == S_WAIT),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      done_hist_q <= '0;
      seen_q      <= 1'b0;
      start_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      err_stage_q <= '0;
      result_q    <= '0;
      frame_q     <= '0;
    end else begin
      done_hist_q <= stage_done_i;
      start_q     <= '0;
      done_q      <= 1'b0;
      if (abort_i) begin
        // Abort wins over done and timeout; result and frame count are kept.
        state_q <= S_IDLE;
        idx_q   <= '0;
        seen_q  <= 1'b0;
        busy_q  <= 1'b0;
        error_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: if (enable_i) begin
            state_q <= S_START;
            idx_q   <= '0;
            start_q <= N_STAGES'(1);
            busy_q  <= 1'b1;
          end
          S_START: begin
            state_q <= S_WAIT;
            seen_q  <= |(done_rise & idx_oh);
          end
          S_WAIT: begin
            if (hit) begin
              seen_q <= 1'b0;
              if (idx_q == LAST) begin
                state_q  <= S_DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                frame_q  <= frame_q + FRAME_W'(1);
                result_q <= relu_clamp(last_result_i[DATA_W-1], RELU_EN != 0) ? '0
                                                                              : last_result_i;
              end else begin
                state_q <= S_START;
                idx_q   <= idx_q + IW'(1);
                start_q <= idx_oh << 1;
              end
            end else if (wd_expired) begin
              state_q     <= S_ERROR;
              busy_q      <= 1'b0;
              error_q     <= 1'b1;
              err_stage_q <= idx_q;
            end
          end
          S_DONE: begin
            if (continuous_i && enable_i) begin
              state_q <= S_START;
              idx_q   <= '0;
              start_q <= N_STAGES'(1);
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              idx_q   <= '0;
            end
          end
          S_ERROR: state_q <= S_ERROR;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign stage_start_o = start_q;
  assign result_o      = result_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign error_o       = error_q;
  assign err_stage_o   = err_stage_q;
  assign cur_stage_o   = idx_q;
  assign frame_count_o = frame_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer (3 stages, TIMEOUT=16, FRAME_W=2, ReLU on).
module tb_cnn_layer_sequencer;
  localparam int N = 3, DW = 32, TO = 16, FW = 2;

  logic clk = 1'b0;
  logic rst, enable, continuous, abort;
  logic [N-1:0] stage_start, stage_done, force_done;
  logic [N-1:0] resp_done = '0;
  logic [DW-1:0] last_result, result;
  logic done, busy, error;
  logic [2:0] err_stage, cur_stage;
  logic [FW-1:0] frame_count;

  assign stage_done = resp_done | force_done;

  cnn_layer_sequencer #(.N_STAGES(N), .DATA_W(DW), .TIMEOUT(TO), .FRAME_W(FW), .RELU_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .continuous_i(continuous), .abort_i(abort),
    .stage_start_o(stage_start), .stage_done_i(stage_done), .last_result_i(last_result),
    .result_o(result), .done_o(done), .busy_o(busy), .error_o(error),
    .err_stage_o(err_stage), .cur_stage_o(cur_stage), .frame_count_o(frame_count));

  always #5 clk = ~clk;

  // Stage engine model: pulses done dly[i] cycles after its start; dly 0 = never answers.
  int dly[N];
  int st[N];
  bit pend[N];
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      resp_done[i] <= 1'b0;
      if (!rst) pend[i] <= 1'b0;
      else if (stage_start[i] && dly[i] > 0) begin
        if (dly[i] == 1) resp_done[i] <= 1'b1;
        else begin pend[i] <= 1'b1; st[i] <= cyc; end
      end else if (pend[i] && cyc + 1 == st[i] + dly[i]) begin
        resp_done[i] <= 1'b1;
        pend[i] <= 1'b0;
      end
    end
  end

  // Event log: cycle of every start pulse (with stage) and every done pulse.
  int sc_q[$], ss_q[$], dc_q[$];
  int oh_err = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (stage_start != '0 && !$onehot(stage_start)) oh_err <= oh_err + 1;
      for (int i = 0; i < N; i++) if (stage_start[i]) begin sc_q.push_back(cyc); ss_q.push_back(i); end
      if (done) dc_q.push_back(cyc);
    end
  end

  int checks = 0, errors = 0;
  int frames = 0;
  logic [31:0] model_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
    return ($signed(v) < 0) ? 32'd0 : v;
  endfunction

  task automatic clear_log();
    sc_q.delete(); ss_q.delete(); dc_q.delete();
  endtask

  // One single-shot frame; expected schedule: each stage starts the cycle after the
  // previous stage's done, the frame done pulse the cycle after the last stage's done.
  task automatic run_single(input string tag, input int a, input int b, input int c,
                            input logic [31:0] lr, output int lat);
    int d[N];
    int e, s, n;
    d = '{a, b, c};
    for (int i = 0; i < N; i++) dly[i] = d[i];
    last_result = lr;
    clear_log();
    e = cyc; enable = 1'b1; tick(); enable = 1'b0;
    n = 0;
    while (dc_q.size() == 0 && n < 200) begin tick(); n++; end
    tick(); tick(); tick();
    frames++;
    model_res = relu(lr);
    lat = (dc_q.size() != 0) ? dc_q[0] - e : -1;
    check({tag, " starts"}, sc_q.size(), N);
    s = e + 1;
    for (int i = 0; i < N; i++) begin
      if (i < sc_q.size()) begin
        check($sformatf("%s start%0d cyc", tag, i), sc_q[i], s);
        check($sformatf("%s start%0d stage", tag, i), ss_q[i], i);
      end
      s += d[i] + 1;
    end
    check({tag, " dones"}, dc_q.size(), 1);
    if (dc_q.size() != 0) check({tag, " done cyc"}, dc_q[0], s);
    check({tag, " result"}, result, model_res);
    check({tag, " frames"}, frame_count, frames % 4);
    check({tag, " idle"}, {busy, error}, 2'b00);
  endtask

  typedef struct {
    int d0, d1, d2;
    logic [31:0] lr;
    logic [31:0] res;
    int lat;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int lat, e, s, n, s1, s2, r;
    tbl[0] = '{5, 5, 5, 32'hFFFF_FFF9, 32'h0, 19};
    tbl[1] = '{1, 1, 1, 32'd42, 32'd42, 7};
    tbl[2] = '{2, 7, 3, 32'h8000_0000, 32'h0, 16};
    tbl[3] = '{6, 1, 4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 15};

    rst = 1'b0; enable = 1'b0; continuous = 1'b0; abort = 1'b0;
    force_done = '0; last_result = '0;
    for (int i = 0; i < N; i++) dly[i] = 1;
    tick(); tick();
    check("reset outs", {stage_start, done, busy, error, err_stage, cur_stage, frame_count, result},
          '0);
    rst = 1'b1;
    tick();

    // Table-driven single-shot frames.
    for (int k = 0; k < 4; k++) begin
      run_single($sformatf("tbl%0d", k), tbl[k].d0, tbl[k].d1, tbl[k].d2, tbl[k].lr, lat);
      check($sformatf("tbl%0d latency", k), lat, tbl[k].lat);
      check($sformatf("tbl%0d tbl result", k), result, tbl[k].res);
    end

    // Continuous mode, three back-to-back frames; enable drops during frame 3.
    for (int i = 0; i < N; i++) dly[i] = 5;
    last_result = 32'd42; continuous = 1'b1;
    clear_log();
    e = cyc; enable = 1'b1; tick();
    n = 0;
    while (sc_q.size() < 7 && n < 200) begin tick(); n++; end
    enable = 1'b0;
    n = 0;
    while (dc_q.size() < 3 && n < 200) begin tick(); n++; end
    repeat (4) tick();
    continuous = 1'b0;
    check("cont starts", sc_q.size(), 9);
    check("cont dones", dc_q.size(), 3);
    s = e + 1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        if (f * N + i < sc_q.size()) check($sformatf("cont f%0d s%0d", f, i), sc_q[f * N + i], s);
        s += 6;
      end
      if (f < dc_q.size()) check($sformatf("cont f%0d done", f), dc_q[f], s);
      s += 1;
    end
    frames += 3; model_res = 32'd42;
    check("cont result", result, 32'd42);
    check("cont frames", frame_count, frames % 4);
    check("cont idle", busy, 1'b0);

    // Stage 0 done held high from before: must not advance; stage 2 rise in stage 1 ignored.
    force_done = 3'b001;
    dly = '{0, 4, 3};
    last_result = 32'hFFFF_FFFB;
    clear_log();
    enable = 1'b1; tick(); enable = 1'b0;
    repeat (8) tick();
    check("held stage", cur_stage, 3'd0);
    check("held busy", busy, 1'b1);
    check("held starts", sc_q.size(), 1);
    force_done[0] = 1'b0; tick();
    force_done[0] = 1'b1; r = cyc; tick(); tick();
    force_done[2] = 1'b1; tick();
    force_done[2] = 1'b0;
    check("foreign rise stage", cur_stage, 3'd1);
    check("foreign rise starts", sc_q.size(), 2);
    n = 0;
    while (dc_q.size() == 0 && n < 100) begin tick(); n++; end
    tick();
    force_done = '0;
    frames++; model_res = 32'd0;
    check("held s1", (sc_q.size() > 1) ? sc_q[1] : -1, r + 1);
    check("held s2", (sc_q.size() > 2) ? sc_q[2] : -1, r + 6);
    check("held done", (dc_q.size() > 0) ? dc_q[0] : -1, r + 10);
    check("held result", result, model_res);
    check("held frames", frame_count, frames % 4);

    // Abort in the same cycle as the final stage done.
    dly = '{2, 2, 2};
    last_result = 32'd77;
    clear_log();
    e = cyc; enable = 1'b1; tick(); enable = 1'b0;
    s2 = e + 1 + 3 + 3;
    while (cyc < s2 + 2) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort done", done, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort stage", cur_stage, 3'd0);
    repeat (3) tick();
    check("abort dones", dc_q.size(), 0);
    check("abort starts", sc_q.size(), 3);
    check("abort frames", frame_count, frames % 4);
    check("abort result", result, model_res);

    // Watchdog: stage 1 never answers.
    dly = '{3, 0, 4};
    clear_log();
    e = cyc; enable = 1'b1; tick(); enable = 1'b0;
    s1 = e + 1 + 4;
    while (cyc < s1 + TO) tick();
    check("wd before err", {error, busy, cur_stage}, {1'b0, 1'b1, 3'd1});
    tick();
    check("wd error", error, 1'b1);
    check("wd err_stage", err_stage, 3'd1);
    check("wd busy", busy, 1'b0);
    enable = 1'b1;
    repeat (10) tick();
    check("wd sticky", error, 1'b1);
    check("wd starts", sc_q.size(), 2);
    check("wd s1 cyc", (sc_q.size() > 1) ? sc_q[1] : -1, s1);
    enable = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    check("wd abort clr", {error, busy, cur_stage}, '0);
    tick();
    run_single("restart", 2, 3, 2, 32'd100, lat);

    // Randomised single-shot frames against the schedule model.
    for (int k = 0; k < 12; k++)
      run_single($sformatf("rnd%0d", k), $urandom_range(6, 1), $urandom_range(6, 1),
                 $urandom_range(6, 1), $urandom, lat);

    // Positive result held, then reset asserted in the middle of stage 1 WAIT.
    run_single("pre-rst", 2, 2, 2, 32'd55, lat);
    for (int i = 0; i < N; i++) dly[i] = 6;
    clear_log();
    e = cyc; enable = 1'b1; tick(); enable = 1'b0;
    while (cyc < e + 1 + 7 + 2) tick();
    check("mid wait", {busy, cur_stage}, {1'b1, 3'd1});
    rst = 1'b0; tick();
    check("rst outs", {stage_start, done, busy, error, err_stage, cur_stage, frame_count, result},
          '0);
    rst = 1'b1; frames = 0; model_res = '0;
    repeat (10) tick();
    run_single("post-rst", 1, 2, 3, 32'd9, lat);

    check("onehot", oh_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global time limit: simulation did not finish");
    $fatal(1);
  end

endmodule
